// File: rtl/gf180mcu_osu_sc_gp12t3v3__rst_seq.sv
// Staged reset sequencer: holds selected active-low RN domains low for HOLD_CYC
// cycles, then releases them one at a time, lowest index first, GAP_CYC apart.
module gf180mcu_osu_sc_gp12t3v3__rst_seq #(
   parameter int unsigned NDOM     = 4,
   parameter int unsigned HOLD_CYC = 8,
   parameter int unsigned GAP_CYC  = 2,
   parameter int unsigned CW       = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REQ,
   input  logic [NDOM-1:0] MASK,
   output logic [NDOM-1:0] RN,
   output logic            BUSY,
   output logic            DONE
);

   localparam int unsigned   IW        = (NDOM > 1) ? $clog2(NDOM) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ASSERT,
      S_RELEASE,
      S_FIN
   } state_t;

   typedef struct packed {
      logic          found;
      logic [IW-1:0] idx;
   } pick_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   idx;
   logic [NDOM-1:0] mq;
   logic [NDOM-1:0] above;
   pick_t           first_pick;
   pick_t           next_pick;
   logic            req_ok;

   // Priority encoder: lowest set bit of m, scanning downward so the last hit wins.
   function automatic pick_t lowest(input logic [NDOM-1:0] m);
      pick_t p;
      p = '0;
      for (int i = NDOM - 1; i >= 0; i--) begin
         if (m[i]) begin
            p.found = 1'b1;
            p.idx   = IW'(i);
         end
      end
      return p;
   endfunction

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      above = '0;
      for (int i = 0; i < NDOM; i++) begin
         above[i] = mq[i] && (IW'(i) > idx);
      end
   end

   assign first_pick = lowest(mq);
   assign next_pick  = lowest(above);
   assign req_ok     = REQ && (MASK != '0);

   // NOTE: state uses non-blocking assignments; RST is sampled on the clock edge, not asynchronously.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_ASSERT;
         mq    <= '1;
         cnt   <= '0;
         idx   <= '0;
         RN    <= '0;
         BUSY  <= 1'b1;
         DONE  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FIN: begin
               DONE <= 1'b0;
               if (req_ok) begin
                  mq    <= MASK;
                  RN    <= RN & ~MASK;
                  cnt   <= '0;
                  BUSY  <= 1'b1;
                  state <= S_ASSERT;
               end else begin
                  BUSY  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            S_ASSERT: begin
               if (cnt == HOLD_LAST) begin
                  cnt <= '0;
                  if (first_pick.found) begin
                     idx                 <= first_pick.idx;
                     RN[first_pick.idx]  <= 1'b1;
                     state               <= S_RELEASE;
                  end else begin
                     // Unreachable with a non-empty mask; finish cleanly regardless.
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                     state <= S_FIN;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_RELEASE: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (next_pick.found) begin
                     idx               <= next_pick.idx;
                     RN[next_pick.idx] <= 1'b1;
                  end else begin
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                     state <= S_FIN;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__rst_seq.sv
// Directed bench for the staged reset sequencer (NDOM=4, HOLD_CYC=8, GAP_CYC=2).
module tb_gf180mcu_osu_sc_gp12t3v3__rst_seq;

   localparam int NDOM = 4;
   localparam int HOLD = 8;
   localparam int GAP  = 2;

   logic            CLK = 1'b0;
   logic            RST;
   logic            REQ;
   logic [NDOM-1:0] MASK;
   logic [NDOM-1:0] RN;
   logic            BUSY;
   logic            DONE;

   int tests_run = 0;
   int tests_failed = 0;

   gf180mcu_osu_sc_gp12t3v3__rst_seq #(
      .NDOM(NDOM), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .CW(8)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .REQ (REQ),
      .MASK(MASK),
      .RN  (RN),
      .BUSY(BUSY),
      .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] rn, input logic busy, input logic done);
      check({tag, ".RN"}, 32'(RN), 32'(rn));
      check({tag, ".BUSY"}, 32'(BUSY), 32'(busy));
      check({tag, ".DONE"}, 32'(DONE), 32'(done));
   endtask

   // Checks edges t0+1 .. t0+kmax of a sequence (kmax<0: through the cycle after FIN).
   // Optionally pulses REQ with MASK=1111 before edge t0+req_at.
   task automatic seq_check(input string tag, input logic [3:0] sel, input logic [3:0] base,
                            input int kmax, input int req_at);
      int m;
      int last;
      int kend;
      int j;
      logic [3:0] exp_rn;
      m = 0;
      for (int i = 0; i < NDOM; i++) if (sel[i]) m++;
      last = HOLD + m * GAP;
      kend = (kmax < 0) ? last + 1 : kmax;
      for (int k = 1; k <= kend; k++) begin
         if (k == req_at) begin
            REQ  = 1'b1;
            MASK = 4'b1111;
         end
         tick();
         if (k == req_at) begin
            REQ  = 1'b0;
            MASK = 4'b0000;
         end
         exp_rn = base & ~sel;
         j = 0;
         for (int i = 0; i < NDOM; i++) begin
            if (sel[i]) begin
               if (k >= HOLD + j * GAP) exp_rn[i] = 1'b1;
               j++;
            end
         end
         check_outs($sformatf("%s.k%0d", tag, k), exp_rn, (k < last), (k == last));
      end
   endtask

   initial begin
      RST  = 1'b1;
      REQ  = 1'b0;
      MASK = 4'b0000;

      // Power-up: RST high for three edges, last one is r.
      for (int i = 0; i < 3; i++) begin
         tick();
         check_outs($sformatf("pwr_rst%0d", i), 4'b0000, 1'b1, 1'b0);
      end
      RST = 1'b0;
      seq_check("pwr", 4'b1111, 4'b0000, -1, 0);

      // Soft request on domains 1 and 3 only.
      REQ  = 1'b1;
      MASK = 4'b1010;
      tick();
      REQ  = 1'b0;
      MASK = 4'b0000;
      check_outs("soft_t0", 4'b0101, 1'b1, 1'b0);
      seq_check("soft", 4'b1010, 4'b1111, -1, 0);

      // Empty mask is ignored.
      REQ  = 1'b1;
      MASK = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_outs($sformatf("empty%0d", i), 4'b1111, 1'b0, 1'b0);
      end
      REQ = 1'b0;

      // Request while busy has no effect.
      REQ  = 1'b1;
      MASK = 4'b1111;
      tick();
      REQ  = 1'b0;
      MASK = 4'b0000;
      check_outs("busy_t0", 4'b0000, 1'b1, 1'b0);
      seq_check("busy", 4'b1111, 4'b1111, -1, 5);

      // Reset in the middle of a sequence.
      REQ  = 1'b1;
      MASK = 4'b0011;
      tick();
      REQ  = 1'b0;
      MASK = 4'b0000;
      check_outs("abort_t0", 4'b1100, 1'b1, 1'b0);
      seq_check("abort", 4'b0011, 4'b1111, 8, 0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check_outs("abort_rst", 4'b0000, 1'b1, 1'b0);
      seq_check("abort_pwr", 4'b1111, 4'b0000, -1, 0);

      // Back-to-back: REQ held through FIN restarts at the edge that ends FIN.
      REQ  = 1'b1;
      MASK = 4'b0100;
      tick();
      check_outs("b2b_t0", 4'b1011, 1'b1, 1'b0);
      seq_check("b2b_first", 4'b0100, 4'b1111, HOLD + GAP, 0);
      tick();
      REQ  = 1'b0;
      MASK = 4'b0000;
      check_outs("b2b_restart", 4'b1011, 1'b1, 1'b0);
      seq_check("b2b_second", 4'b0100, 4'b1111, -1, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global time bound so the bench always ends by itself.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__rst_seq.md
# gf180mcu_osu_sc_gp12t3v3__rst_seq

Staged reset sequencer for banks of `dffr_1` flops in the 12-track 3.3 V library. It drives one active-low `RN` line per flop domain. On power-up or a soft request, it holds the selected domains in reset for a programmable minimum width, then releases them one at a time with a fixed gap. Each domain therefore sees clean `RN` recovery/removal relative to `CLK`, and inrush from simultaneous release is avoided. It sits between the chip reset/control logic and the flop banks it services.

## Interface
- `NDOM`, 4: number of reset domains (1..16).
- `HOLD_CYC`, 8: cycles all selected `RN` stay low before the first release (≥1).
- `GAP_CYC`, 2: cycles between consecutive domain releases, and after the last one (≥1).
- `CW`, 8: counter width; `HOLD_CYC` and `GAP_CYC` must each be < 2**`CW`.

Ports:
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `REQ`  in  1  soft reset request, sampled each edge.
- `MASK`  in  `NDOM`  domains to reset, sampled with `REQ`.
- `RN`  out  `NDOM`  registered active-low reset to each flop domain.
- `BUSY`  out  1  high while a sequence is in progress.
- `DONE`  out  1  one-cycle pulse when a sequence completes.

## Operation
- States are IDLE, ASSERT, RELEASE and FIN. It has one counter `cnt` (`CW` bits), one index `idx` (log2 `NDOM`) and one latched mask `mq` (`NDOM`).
- `RST` high at an edge sets:
  - state to ASSERT
  - `mq` to all ones, `cnt` to 0
  - `RN` to all zeros, `BUSY` to 1, `DONE` to 0
- `RST` overrides everything, including a sequence already in progress.
- IDLE or FIN, with `REQ`=1 and `MASK`≠0: latch `mq`=`MASK`, clear `RN[i]` for every set bit, set `cnt`=0, go to ASSERT. Unselected `RN` bits are untouched.
- IDLE or FIN, with `REQ`=1 and `MASK`=0: the request is ignored; no output changes and no `DONE`.
- ASSERT: `cnt` increments each edge. At the edge where `cnt`==`HOLD_CYC`-1:
  - `idx` becomes the lowest set bit of `mq`
  - `RN[idx]` becomes 1
  - `cnt` becomes 0 and state becomes RELEASE
- RELEASE: `cnt` increments each edge. At the edge where `cnt`==`GAP_CYC`-1:
  - if a higher set bit of `mq` exists, `idx` moves to it, `RN[idx]` becomes 1 and `cnt` becomes 0
  - otherwise, go to FIN
- Release order is strictly ascending index; unselected indices are skipped with no extra cycles.
- FIN lasts one cycle: `DONE`=1, `BUSY`=0. At the next edge it goes to IDLE, or to ASSERT if a valid `REQ` is present.
- `REQ` while `BUSY`=1 is ignored; there is no queueing and no effect on timing.
- `RN` is driven directly from flops and is glitch-free. A bit of `RN` never rises outside a release edge and never falls except on `RST` or request acceptance.

## Timing
- Let t0 be the edge that accepts `REQ`, or the last edge with `RST`=1.
- `RN` low for selected domains is visible from t0.
- The k-th selected domain (k=0..m-1, m = popcount of `mq`) releases at edge t0+`HOLD_CYC`+k·`GAP_CYC`.
- The FIN cycle follows edge t0+`HOLD_CYC`+m·`GAP_CYC`. `DONE` is high and `BUSY` is low for that cycle only.
- `BUSY` rises at t0 and is 1 in ASSERT and RELEASE.
- Reset values: `RN`=0, `BUSY`=1, `DONE`=0.
- Minimum `RN` low width is `HOLD_CYC` full `CLK` periods.
- Recovery margin from a release edge to the next `CLK` edge is one full period.

## Test plan
With `NDOM`=4, `HOLD_CYC`=8, `GAP_CYC`=2:
- **Power-up:** `RST`=1 for 3 cycles, last high edge r.
  - `RN`=0000 throughout `RST`.
  - `RN[0..3]` rise at r+8, r+10, r+12, r+14.
  - `DONE` pulses after r+16.
  - `BUSY` is 1 from r until that cycle.
- **Soft request:** `REQ`=1, `MASK`=1010 at t0 with `RN`=1111.
  - `RN`=0101 from t0.
  - `RN[1]` rises at t0+8, `RN[3]` at t0+10.
  - `DONE` pulses after t0+12.
  - `RN[0]` and `RN[2]` never drop.
- **Empty mask:** `REQ`=1, `MASK`=0000 in IDLE.
  - `RN` stays 1111, `BUSY` stays 0, no `DONE` pulse.
- **Request while busy:** `REQ` pulsed at t0+5 during a `MASK`=1111 sequence.
  - Release edges are unchanged; exactly one `DONE` pulse.
- **Reset mid-sequence:** `RST`=1 at t0+9 of a `MASK`=0011 sequence.
  - `RN`=0000 from t0+9.
  - Full power-up release order follows from that edge.
  - No `DONE` pulse from the aborted sequence.
- **Back-to-back:** `REQ`=1, `MASK`=0100 held through the FIN cycle.
  - `DONE` still pulses.
  - The new sequence starts at the edge ending FIN: `RN[2]` low from that edge and high 8 edges later.
